// File: rtl/serial_subtractor_pkg.sv
// Shared definitions for the bit-serial subtractor: state encoding and default width.
package serial_subtractor_pkg;

    localparam int DEF_W = 4;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE  = ST_IDLE,
        S_SHIFT = ST_SHIFT,
        S_DONE  = ST_DONE
    } state_t;

endpackage

// File: rtl/serial_subtractor_half_subtractor.sv
// One-bit half subtractor: D = A - B, Bo set when A < B.
module serial_subtractor_half_subtractor (
    input  logic a_i,
    input  logic b_i,
    output logic d_o,
    output logic bo_o
);

    assign d_o  = a_i ^ b_i;
    assign bo_o = ~a_i & b_i;

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial ripple-borrow subtractor: Diff = X - Y - Bin, one bit per cycle, LSB first.
// A single full-subtract cell (two half subtractors) is reused every SHIFT cycle; the
// borrow between bit positions lives in a flop instead of a combinational chain.
//
// state   | meaning
// --------+-----------------------------------------------------------------
// S_IDLE  | waiting for start; Diff/Bout hold the last completed result
// S_SHIFT | one result bit per cycle from the operand shift-register LSBs
// S_DONE  | one-cycle done pulse; result already registered on Diff/Bout
module serial_subtractor
    import serial_subtractor_pkg::*;
#(
    parameter int W     = DEF_W,
    parameter int CNT_W = $clog2(W + 1)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [W-1:0] X,
    input  logic [W-1:0] Y,
    input  logic         Bin,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] Diff,
    output logic         Bout
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(W - 1);

    state_t           state_q, state_d;
    logic [W-1:0]     a_q, a_d;
    logic [W-1:0]     b_q, b_d;
    logic [W-1:0]     res_q, res_d;
    logic [W-1:0]     diff_q, diff_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             brw_q, brw_d;
    logic             bout_q, bout_d;

    logic             hs1_d, hs1_bo;
    logic             bit_d, hs2_bo;
    logic             brw_n;
    logic [W-1:0]     res_shift;

    // First stage subtracts the operand bits, second stage subtracts the running borrow.
    serial_subtractor_half_subtractor u_hs_ab (
        .a_i  (a_q[0]),
        .b_i  (b_q[0]),
        .d_o  (hs1_d),
        .bo_o (hs1_bo)
    );

    serial_subtractor_half_subtractor u_hs_brw (
        .a_i  (hs1_d),
        .b_i  (brw_q),
        .d_o  (bit_d),
        .bo_o (hs2_bo)
    );

    assign brw_n = hs1_bo | hs2_bo;

    // New bit enters at the MSB so after W shifts the LSB-first stream lands in place.
    // Written as shift/OR so it also holds for W=1.
    assign res_shift = (res_q >> 1) | (W'(bit_d) << (W - 1));

    // Next-state and datapath update; everything holds unless the state says otherwise.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        cnt_d   = cnt_q;
        brw_d   = brw_q;
        diff_d  = diff_q;
        bout_d  = bout_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    a_d     = X;
                    b_d     = Y;
                    brw_d   = Bin;
                    res_d   = '0;
                    cnt_d   = '0;
                    state_d = S_SHIFT;
                end
            end
            S_SHIFT: begin
                a_d   = a_q >> 1;
                b_d   = b_q >> 1;
                brw_d = brw_n;
                res_d = res_shift;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_CNT) begin
                    // Outputs change only here, so they stay stable while busy.
                    diff_d  = res_shift;
                    bout_d  = brw_n;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset wins over any operation in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            cnt_q   <= '0;
            brw_q   <= 1'b0;
            diff_q  <= '0;
            bout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            cnt_q   <= cnt_d;
            brw_q   <= brw_d;
            diff_q  <= diff_d;
            bout_q  <= bout_d;
        end
    end

    assign busy = (state_q != S_IDLE);
    assign done = (state_q == S_DONE);
    assign Diff = diff_q;
    assign Bout = bout_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed bench for serial_subtractor: a W=4 and a W=1 instance share clock and reset.
// Cycle numbering: the period right after the start-accepting edge is cycle 1.
module tb_serial_subtractor;

    logic       clk;
    logic       rst;

    logic       start4;
    logic [3:0] x4, y4;
    logic       bin4;
    logic       busy4, done4, bout4;
    logic [3:0] diff4;

    logic       start1;
    logic [0:0] x1, y1;
    logic       bin1;
    logic       busy1, done1, bout1;
    logic [0:0] diff1;

    int n_chk;
    int n_err;
    logic [3:0] prev_diff4;
    logic       prev_bout4;

    serial_subtractor #(.W(4)) u_dut4 (
        .clk   (clk),
        .rst   (rst),
        .start (start4),
        .X     (x4),
        .Y     (y4),
        .Bin   (bin4),
        .busy  (busy4),
        .done  (done4),
        .Diff  (diff4),
        .Bout  (bout4)
    );

    serial_subtractor #(.W(1)) u_dut1 (
        .clk   (clk),
        .rst   (rst),
        .start (start1),
        .X     (x1),
        .Y     (y1),
        .Bin   (bin1),
        .busy  (busy1),
        .done  (done1),
        .Diff  (diff1),
        .Bout  (bout1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One W=4 operation: checks busy, held outputs, latency, result and the single-cycle done.
    task automatic op4(input logic [3:0] x, input logic [3:0] y, input logic bin,
                       input logic [3:0] exp_diff, input logic exp_bout, input string tag);
        int cyc;
        @(negedge clk);
        start4 = 1'b1; x4 = x; y4 = y; bin4 = bin;
        @(posedge clk); #1;
        cyc = 1;
        check({tag, ".busy"}, busy4, 1'b1);
        check({tag, ".hold_diff"}, diff4, prev_diff4);
        check({tag, ".hold_bout"}, bout4, prev_bout4);
        @(negedge clk);
        start4 = 1'b0;
        x4 = 4'(~x); y4 = 4'(~y); bin4 = ~bin;
        while (!done4 && cyc < 20) begin
            @(posedge clk); #1;
            cyc++;
        end
        check({tag, ".lat"}, cyc, 5);
        check({tag, ".diff"}, diff4, exp_diff);
        check({tag, ".bout"}, bout4, exp_bout);
        @(posedge clk); #1;
        check({tag, ".done_1cyc"}, done4, 1'b0);
        check({tag, ".idle"}, busy4, 1'b0);
        prev_diff4 = exp_diff;
        prev_bout4 = exp_bout;
    endtask

    task automatic op1(input logic x, input logic y, input logic bin,
                       input logic exp_diff, input logic exp_bout, input string tag);
        int cyc;
        @(negedge clk);
        start1 = 1'b1; x1 = x; y1 = y; bin1 = bin;
        @(posedge clk); #1;
        cyc = 1;
        @(negedge clk);
        start1 = 1'b0;
        while (!done1 && cyc < 10) begin
            @(posedge clk); #1;
            cyc++;
        end
        check({tag, ".lat"}, cyc, 2);
        check({tag, ".diff"}, diff1, exp_diff);
        check({tag, ".bout"}, bout1, exp_bout);
        @(posedge clk); #1;
        check({tag, ".done_1cyc"}, done1, 1'b0);
    endtask

    initial begin
        int pulses;
        int cyc;
        logic [1:0] m;
        logic rx, ry, rb;

        n_chk = 0;
        n_err = 0;
        prev_diff4 = 4'h0;
        prev_bout4 = 1'b0;
        start4 = 1'b0; x4 = '0; y4 = '0; bin4 = 1'b0;
        start1 = 1'b0; x1 = '0; y1 = '0; bin1 = 1'b0;

        // Reset held for two edges.
        rst = 1'b1;
        @(posedge clk);
        @(posedge clk); #1;
        check("rst.busy", busy4, 1'b0);
        check("rst.done", done4, 1'b0);
        check("rst.diff", diff4, 4'h0);
        check("rst.bout", bout4, 1'b0);
        check("rst.busy_w1", busy1, 1'b0);
        @(negedge clk);
        rst = 1'b0;

        // Directed W=4 vectors.
        op4(4'd9,  4'd3,  1'b0, 4'h6, 1'b0, "sub_9_3");
        op4(4'd3,  4'd9,  1'b0, 4'hA, 1'b1, "sub_3_9");
        op4(4'd0,  4'd0,  1'b1, 4'hF, 1'b1, "dec_wrap");
        op4(4'd10, 4'd5,  1'b1, 4'h4, 1'b0, "sub_10_5_b");
        op4(4'd8,  4'd8,  1'b1, 4'hF, 1'b1, "eq_borrow");
        op4(4'd15, 4'd15, 1'b0, 4'h0, 1'b0, "sub_15_15");

        // Start held high through busy: the first op uses 15-15, the second picks up 5-2
        // only after returning to IDLE.
        @(negedge clk);
        start4 = 1'b1; x4 = 4'd15; y4 = 4'd15; bin4 = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        x4 = 4'd5; y4 = 4'd2;
        cyc = 1;
        while (!done4 && cyc < 20) begin
            @(posedge clk); #1;
            cyc++;
        end
        check("held.first_diff", diff4, 4'h0);
        @(posedge clk); #1;
        check("held.idle_gap", busy4, 1'b0);
        @(posedge clk); #1;
        check("held.reaccept", busy4, 1'b1);
        @(negedge clk);
        start4 = 1'b0;
        pulses = 0;
        for (int i = 0; i < 15; i++) begin
            @(posedge clk); #1;
            if (done4) pulses++;
        end
        check("held.one_extra", pulses, 1);
        check("held.second_diff", diff4, 4'h3);
        check("held.second_bout", bout4, 1'b0);

        // Reset during the second SHIFT cycle of a 9-3 operation.
        @(negedge clk);
        start4 = 1'b1; x4 = 4'd9; y4 = 4'd3; bin4 = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        start4 = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        check("midrst.busy", busy4, 1'b0);
        check("midrst.done", done4, 1'b0);
        check("midrst.diff", diff4, 4'h0);
        check("midrst.bout", bout4, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        pulses = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (done4) pulses++;
        end
        check("midrst.no_done", pulses, 0);
        prev_diff4 = 4'h0;
        prev_bout4 = 1'b0;
        op4(4'd9, 4'd3, 1'b0, 4'h6, 1'b0, "after_rst");

        // W=1 build.
        op1(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, "w1_0_1");
        for (int i = 0; i < 12; i++) begin
            rx = 1'($urandom_range(1, 0));
            ry = 1'($urandom_range(1, 0));
            rb = 1'($urandom_range(1, 0));
            m  = {1'b0, rx} - {1'b0, ry} - {1'b0, rb};
            op1(rx, ry, rb, m[0], m[1], $sformatf("w1_rand%0d", i));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
